// File: rtl/rvfi_commit_gen.sv
// RVFI commit packet generator: per-ROB-tag shadow records, registered in-order commit packets.
// Optional protocol checking is built when RVFI_CHECK_EN is defined; otherwise err is tied to 0.
module rvfi_commit_gen #(
    parameter int ROB_DEPTH = 16,
    parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp_valid,
    input  logic [TAG_W-1:0] disp_tag,
    input  logic [31:0]      disp_inst,
    input  logic [31:0]      disp_pc,
    input  logic [4:0]       disp_rs1_addr,
    input  logic [4:0]       disp_rs2_addr,
    input  logic [4:0]       disp_rd_addr,
    input  logic             opnd_valid,
    input  logic [TAG_W-1:0] opnd_tag,
    input  logic [31:0]      opnd_rs1_rdata,
    input  logic [31:0]      opnd_rs2_rdata,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic [31:0]      wb_rd_wdata,
    input  logic [31:0]      wb_pc_wdata,
    input  logic             mem_valid,
    input  logic [TAG_W-1:0] mem_tag,
    input  logic [31:0]      mem_addr,
    input  logic [3:0]       mem_rmask,
    input  logic [3:0]       mem_wmask,
    input  logic [31:0]      mem_rdata,
    input  logic [31:0]      mem_wdata,
    input  logic             commit_valid,
    input  logic [TAG_W-1:0] commit_tag,
    input  logic             flush,
    output logic             rvfi_valid,
    output logic [63:0]      rvfi_order,
    output logic [31:0]      rvfi_inst,
    output logic [4:0]       rvfi_rs1_addr,
    output logic [4:0]       rvfi_rs2_addr,
    output logic [31:0]      rvfi_rs1_rdata,
    output logic [31:0]      rvfi_rs2_rdata,
    output logic [4:0]       rvfi_rd_addr,
    output logic [31:0]      rvfi_rd_wdata,
    output logic [31:0]      rvfi_pc_rdata,
    output logic [31:0]      rvfi_pc_wdata,
    output logic [31:0]      rvfi_mem_addr,
    output logic [3:0]       rvfi_mem_rmask,
    output logic [3:0]       rvfi_mem_wmask,
    output logic [31:0]      rvfi_mem_rdata,
    output logic [31:0]      rvfi_mem_wdata,
    output logic             err
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc_rdata;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rd_wdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } entry_t;

    entry_t               ent [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] alloc_q, alloc_n;
    logic [ROB_DEPTH-1:0] opnd_done_q, opnd_done_n;
    logic [63:0]          order_q;
    logic                 opnd_hit, wb_hit, mem_hit, disp_en;
    entry_t               pkt;
    logic                 pkt_opnd;

    assign opnd_hit = opnd_valid && alloc_q[opnd_tag];
    assign wb_hit   = wb_valid   && alloc_q[wb_tag];
    assign mem_hit  = mem_valid  && alloc_q[mem_tag];
    assign disp_en  = disp_valid && !flush;

    // Dispatch is written last so it wins over any stale update landing on a re-allocated tag.
    always_ff @(posedge clk) begin
        if (opnd_hit) begin
            ent[opnd_tag].rs1_rdata <= opnd_rs1_rdata;
            ent[opnd_tag].rs2_rdata <= opnd_rs2_rdata;
        end
        if (wb_hit) begin
            ent[wb_tag].rd_wdata <= wb_rd_wdata;
            ent[wb_tag].pc_wdata <= wb_pc_wdata;
        end
        if (mem_hit) begin
            ent[mem_tag].mem_addr  <= mem_addr;
            ent[mem_tag].mem_rmask <= mem_rmask;
            ent[mem_tag].mem_wmask <= mem_wmask;
            ent[mem_tag].mem_rdata <= mem_rdata;
            ent[mem_tag].mem_wdata <= mem_wdata;
        end
        if (disp_en) begin
            ent[disp_tag].inst      <= disp_inst;
            ent[disp_tag].pc_rdata  <= disp_pc;
            ent[disp_tag].rs1_addr  <= disp_rs1_addr;
            ent[disp_tag].rs2_addr  <= disp_rs2_addr;
            ent[disp_tag].rd_addr   <= disp_rd_addr;
            ent[disp_tag].mem_addr  <= '0;
            ent[disp_tag].mem_rmask <= '0;
            ent[disp_tag].mem_wmask <= '0;
            ent[disp_tag].mem_rdata <= '0;
            ent[disp_tag].mem_wdata <= '0;
        end
    end

    always_comb begin
        alloc_n     = alloc_q;
        opnd_done_n = opnd_done_q;
        if (opnd_hit)
            opnd_done_n[opnd_tag] = 1'b1;
        if (commit_valid) begin
            alloc_n[commit_tag]     = 1'b0;
            opnd_done_n[commit_tag] = 1'b0;
        end
        if (disp_en) begin
            alloc_n[disp_tag]     = 1'b1;
            opnd_done_n[disp_tag] = 1'b0;
        end
        if (flush) begin
            alloc_n     = '0;
            opnd_done_n = '0;
        end
    end

    // Packet is built from the stored entry with same-cycle updates forwarded in.
    always_comb begin
        pkt      = ent[commit_tag];
        pkt_opnd = opnd_done_q[commit_tag];
        if (opnd_hit && opnd_tag == commit_tag) begin
            pkt.rs1_rdata = opnd_rs1_rdata;
            pkt.rs2_rdata = opnd_rs2_rdata;
            pkt_opnd      = 1'b1;
        end
        if (wb_hit && wb_tag == commit_tag) begin
            pkt.rd_wdata = wb_rd_wdata;
            pkt.pc_wdata = wb_pc_wdata;
        end
        if (mem_hit && mem_tag == commit_tag) begin
            pkt.mem_addr  = mem_addr;
            pkt.mem_rmask = mem_rmask;
            pkt.mem_wmask = mem_wmask;
            pkt.mem_rdata = mem_rdata;
            pkt.mem_wdata = mem_wdata;
        end
        if (!pkt_opnd || pkt.rs1_addr == 5'd0)
            pkt.rs1_rdata = '0;
        if (!pkt_opnd || pkt.rs2_addr == 5'd0)
            pkt.rs2_rdata = '0;
        if (pkt.rd_addr == 5'd0)
            pkt.rd_wdata = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_q        <= '0;
            opnd_done_q    <= '0;
            order_q        <= '0;
            rvfi_valid     <= 1'b0;
            rvfi_order     <= '0;
            rvfi_inst      <= '0;
            rvfi_rs1_addr  <= '0;
            rvfi_rs2_addr  <= '0;
            rvfi_rs1_rdata <= '0;
            rvfi_rs2_rdata <= '0;
            rvfi_rd_addr   <= '0;
            rvfi_rd_wdata  <= '0;
            rvfi_pc_rdata  <= '0;
            rvfi_pc_wdata  <= '0;
            rvfi_mem_addr  <= '0;
            rvfi_mem_rmask <= '0;
            rvfi_mem_wmask <= '0;
            rvfi_mem_rdata <= '0;
            rvfi_mem_wdata <= '0;
        end else begin
            alloc_q     <= alloc_n;
            opnd_done_q <= opnd_done_n;
            rvfi_valid  <= commit_valid;
            if (commit_valid) begin
                order_q        <= order_q + 64'd1;
                rvfi_order     <= order_q;
                rvfi_inst      <= pkt.inst;
                rvfi_rs1_addr  <= pkt.rs1_addr;
                rvfi_rs2_addr  <= pkt.rs2_addr;
                rvfi_rs1_rdata <= pkt.rs1_rdata;
                rvfi_rs2_rdata <= pkt.rs2_rdata;
                rvfi_rd_addr   <= pkt.rd_addr;
                rvfi_rd_wdata  <= pkt.rd_wdata;
                rvfi_pc_rdata  <= pkt.pc_rdata;
                rvfi_pc_wdata  <= pkt.pc_wdata;
                rvfi_mem_addr  <= pkt.mem_addr;
                rvfi_mem_rmask <= pkt.mem_rmask;
                rvfi_mem_wmask <= pkt.mem_wmask;
                rvfi_mem_rdata <= pkt.mem_rdata;
                rvfi_mem_wdata <= pkt.mem_wdata;
            end
        end
    end

`ifdef RVFI_CHECK_EN
    logic [ROB_DEPTH-1:0] wb_done_q, wb_done_n;
    logic                 err_n;

    always_comb begin
        wb_done_n = wb_done_q;
        if (wb_hit)
            wb_done_n[wb_tag] = 1'b1;
        if (commit_valid)
            wb_done_n[commit_tag] = 1'b0;
        if (disp_en)
            wb_done_n[disp_tag] = 1'b0;
        if (flush)
            wb_done_n = '0;

        err_n = err
            | (commit_valid && (!alloc_q[commit_tag] ||
                                !(wb_done_q[commit_tag] || (wb_hit && wb_tag == commit_tag))))
            | (disp_valid && alloc_q[disp_tag] && !(commit_valid && commit_tag == disp_tag))
            | (opnd_valid && !alloc_q[opnd_tag])
            | (wb_valid   && !alloc_q[wb_tag])
            | (mem_valid  && !alloc_q[mem_tag]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_done_q <= '0;
            err       <= 1'b0;
        end else begin
            wb_done_q <= wb_done_n;
            err       <= err_n;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_commit_gen.sv
// Bench for rvfi_commit_gen: directed scenarios plus a randomized in-order ROB stream,
// checked against an entry-level reference model of the shadow records.
module tb_rvfi_commit_gen;
    localparam int PW = 376;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_valid, opnd_valid, wb_valid, mem_valid, commit_valid, flush;
    logic [3:0]  disp_tag, opnd_tag, wb_tag, mem_tag, commit_tag;
    logic [31:0] disp_inst, disp_pc, opnd_rs1_rdata, opnd_rs2_rdata, wb_rd_wdata, wb_pc_wdata;
    logic [4:0]  disp_rs1_addr, disp_rs2_addr, disp_rd_addr;
    logic [31:0] mem_addr, mem_rdata, mem_wdata;
    logic [3:0]  mem_rmask, mem_wmask;

    logic        rvfi_valid, err;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_inst, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_pc_rdata;
    logic [31:0] rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;

    rvfi_commit_gen #(.ROB_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_tag(disp_tag), .disp_inst(disp_inst), .disp_pc(disp_pc),
        .disp_rs1_addr(disp_rs1_addr), .disp_rs2_addr(disp_rs2_addr), .disp_rd_addr(disp_rd_addr),
        .opnd_valid(opnd_valid), .opnd_tag(opnd_tag),
        .opnd_rs1_rdata(opnd_rs1_rdata), .opnd_rs2_rdata(opnd_rs2_rdata),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_rd_wdata(wb_rd_wdata), .wb_pc_wdata(wb_pc_wdata),
        .mem_valid(mem_valid), .mem_tag(mem_tag), .mem_addr(mem_addr), .mem_rmask(mem_rmask),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .flush(flush),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_inst(rvfi_inst),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        alloc, od, wd;
        logic [31:0] inst, pc;
        logic [4:0]  rs1a, rs2a, rda;
        logic [31:0] rs1d, rs2d, rdw, pcw, maddr;
        logic [3:0]  rm, wm;
        logic [31:0] mrd, mwd;
    } ment_t;

    ment_t       m [16];
    logic [63:0] m_order;
    logic        m_err;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] dut_pkt();
        return {rvfi_valid, rvfi_order, rvfi_inst, rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata,
                rvfi_rs2_rdata, rvfi_rd_addr, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata,
                rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m[i].alloc = 1'b0; m[i].od = 1'b0; m[i].wd = 1'b0;
        end
        m_order = '0;
        m_err   = 1'b0;
    endtask

    task automatic clr_inputs();
        disp_valid = 0; opnd_valid = 0; wb_valid = 0; mem_valid = 0; commit_valid = 0; flush = 0;
        disp_tag = 4'($urandom); opnd_tag = 4'($urandom); wb_tag = 4'($urandom);
        mem_tag = 4'($urandom); commit_tag = 4'($urandom);
        disp_inst = $urandom; disp_pc = $urandom; disp_rs1_addr = 5'($urandom);
        disp_rs2_addr = 5'($urandom); disp_rd_addr = 5'($urandom);
        opnd_rs1_rdata = $urandom; opnd_rs2_rdata = $urandom;
        wb_rd_wdata = $urandom; wb_pc_wdata = $urandom;
        mem_addr = $urandom; mem_rmask = 4'($urandom); mem_wmask = 4'($urandom);
        mem_rdata = $urandom; mem_wdata = $urandom;
    endtask

    task automatic set_disp(input int tag, input logic [31:0] inst, input logic [31:0] pc,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        disp_valid = 1; disp_tag = tag[3:0]; disp_inst = inst; disp_pc = pc;
        disp_rs1_addr = rs1; disp_rs2_addr = rs2; disp_rd_addr = rd;
    endtask

    task automatic set_opnd(input int tag, input logic [31:0] d1, input logic [31:0] d2);
        opnd_valid = 1; opnd_tag = tag[3:0]; opnd_rs1_rdata = d1; opnd_rs2_rdata = d2;
    endtask

    task automatic set_wb(input int tag, input logic [31:0] rd, input logic [31:0] pc);
        wb_valid = 1; wb_tag = tag[3:0]; wb_rd_wdata = rd; wb_pc_wdata = pc;
    endtask

    task automatic set_mem(input int tag, input logic [31:0] a, input logic [3:0] rm,
                           input logic [3:0] wm, input logic [31:0] rd, input logic [31:0] wd);
        mem_valid = 1; mem_tag = tag[3:0]; mem_addr = a; mem_rmask = rm; mem_wmask = wm;
        mem_rdata = rd; mem_wdata = wd;
    endtask

    task automatic set_commit(input int tag);
        commit_valid = 1; commit_tag = tag[3:0];
    endtask

    // One clock: predict from the model and the driven inputs, advance the model, then compare.
    task automatic step(input string tag);
        logic [PW-1:0] exp;
        logic          ev;
        ment_t         e;
        int            t, d;
        ev  = commit_valid;
        exp = '0;
        if (commit_valid) begin
            t = int'(commit_tag);
            e = m[t];
            if (e.alloc) begin
                if (opnd_valid && opnd_tag == commit_tag) begin
                    e.rs1d = opnd_rs1_rdata; e.rs2d = opnd_rs2_rdata; e.od = 1'b1;
                end
                if (wb_valid && wb_tag == commit_tag) begin
                    e.rdw = wb_rd_wdata; e.pcw = wb_pc_wdata; e.wd = 1'b1;
                end
                if (mem_valid && mem_tag == commit_tag) begin
                    e.maddr = mem_addr; e.rm = mem_rmask; e.wm = mem_wmask;
                    e.mrd = mem_rdata; e.mwd = mem_wdata;
                end
            end
            exp = {1'b1, m_order, e.inst, e.rs1a, e.rs2a,
                   (e.od && e.rs1a != 0) ? e.rs1d : 32'h0,
                   (e.od && e.rs2a != 0) ? e.rs2d : 32'h0,
                   e.rda, (e.rda != 0) ? e.rdw : 32'h0, e.pc, e.pcw,
                   e.maddr, e.rm, e.wm, e.mrd, e.mwd};
`ifdef RVFI_CHECK_EN
            if (!(e.alloc && e.wd)) m_err = 1'b1;
`endif
        end
`ifdef RVFI_CHECK_EN
        if (disp_valid && m[disp_tag].alloc && !(commit_valid && commit_tag == disp_tag)) m_err = 1'b1;
        if (opnd_valid && !m[opnd_tag].alloc) m_err = 1'b1;
        if (wb_valid && !m[wb_tag].alloc) m_err = 1'b1;
        if (mem_valid && !m[mem_tag].alloc) m_err = 1'b1;
`endif
        if (commit_valid) m_order = m_order + 64'd1;
        if (opnd_valid && m[opnd_tag].alloc) begin
            m[opnd_tag].rs1d = opnd_rs1_rdata; m[opnd_tag].rs2d = opnd_rs2_rdata; m[opnd_tag].od = 1'b1;
        end
        if (wb_valid && m[wb_tag].alloc) begin
            m[wb_tag].rdw = wb_rd_wdata; m[wb_tag].pcw = wb_pc_wdata; m[wb_tag].wd = 1'b1;
        end
        if (mem_valid && m[mem_tag].alloc) begin
            m[mem_tag].maddr = mem_addr; m[mem_tag].rm = mem_rmask; m[mem_tag].wm = mem_wmask;
            m[mem_tag].mrd = mem_rdata; m[mem_tag].mwd = mem_wdata;
        end
        if (commit_valid) begin
            m[commit_tag].alloc = 1'b0; m[commit_tag].od = 1'b0; m[commit_tag].wd = 1'b0;
        end
        if (flush) begin
            for (int i = 0; i < 16; i++) begin
                m[i].alloc = 1'b0; m[i].od = 1'b0; m[i].wd = 1'b0;
            end
        end else if (disp_valid) begin
            d = int'(disp_tag);
            m[d].inst = disp_inst; m[d].pc = disp_pc; m[d].rs1a = disp_rs1_addr;
            m[d].rs2a = disp_rs2_addr; m[d].rda = disp_rd_addr;
            m[d].maddr = '0; m[d].rm = '0; m[d].wm = '0; m[d].mrd = '0; m[d].mwd = '0;
            m[d].alloc = 1'b1; m[d].od = 1'b0; m[d].wd = 1'b0;
        end
        @(posedge clk);
        #1;
        chk({tag, ":valid"}, PW'(rvfi_valid), PW'(ev));
        if (ev) chk({tag, ":pkt"}, dut_pkt(), exp);
        chk({tag, ":err"}, PW'(err), PW'(m_err));
        clr_inputs();
    endtask

    initial begin
        int q[$];
        int tail;
        rst = 1'b1;
        clr_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", dut_pkt(), '0);
        chk("reset_err", PW'(err), '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ADDI x1,x0,5
        set_disp(0, 32'h00500093, 32'h60000000, 5'd0, 5'd0, 5'd1); step("addi_disp");
        set_opnd(0, 32'h77, 32'h0);                               step("addi_opnd");
        set_wb(0, 32'd5, 32'h60000004);                           step("addi_wb");
        set_commit(0);                                            step("addi_commit");
        chk("addi_order", PW'(rvfi_order), PW'(0));
        chk("addi_rd", PW'(rvfi_rd_addr), PW'(1));
        chk("addi_rd_wdata", PW'(rvfi_rd_wdata), PW'(5));
        chk("addi_rs1_rdata", PW'(rvfi_rs1_rdata), PW'(0));

        // Three back-to-back commits
        set_disp(1, 32'h002081b3, 32'h60000004, 5'd1, 5'd2, 5'd3); step("b2b_d1");
        set_disp(2, 32'h40208233, 32'h60000008, 5'd1, 5'd2, 5'd4);
        set_opnd(1, 32'h11, 32'h22); set_wb(1, 32'h33, 32'h60000008); step("b2b_d2");
        set_disp(3, 32'h0020c2b3, 32'h6000000c, 5'd1, 5'd2, 5'd5);
        set_opnd(2, 32'h11, 32'h22); set_wb(2, 32'hffffffef, 32'h6000000c); step("b2b_d3");
        set_opnd(3, 32'h11, 32'h22); set_wb(3, 32'h33, 32'h60000010); step("b2b_w3");
        set_commit(1); step("b2b_c1");
        set_commit(2); step("b2b_c2");
        chk("b2b_order2", PW'(rvfi_order), PW'(2));
        set_commit(3); step("b2b_c3");
        chk("b2b_order3", PW'(rvfi_order), PW'(3));

        // LW with writeback and commit in the same cycle
        set_disp(4, 32'h0000a103, 32'h60000010, 5'd1, 5'd0, 5'd2); step("lw_disp");
        set_opnd(4, 32'h1000, 32'h0);                              step("lw_opnd");
        set_mem(4, 32'h1000, 4'hf, 4'h0, 32'hdeadbeef, 32'h0);    step("lw_mem");
        set_wb(4, 32'hdeadbeef, 32'h60000014); set_commit(4);      step("lw_commit");
        chk("lw_mem_rdata", PW'(rvfi_mem_rdata), PW'(32'hdeadbeef));
        chk("lw_mem_wmask", PW'(rvfi_mem_wmask), PW'(0));
        chk("lw_mem_rmask", PW'(rvfi_mem_rmask), PW'(4'hf));

        // Flush then re-dispatch
        set_disp(5, 32'h00100313, 32'h60000014, 5'd0, 5'd0, 5'd6); step("fl_d5");
        set_disp(6, 32'h00200393, 32'h60000018, 5'd0, 5'd0, 5'd7); step("fl_d6");
        flush = 1; set_disp(7, 32'h00300413, 32'h6000001c, 5'd0, 5'd0, 5'd8); step("fl_flush");
        set_disp(5, 32'h00a00513, 32'h60000100, 5'd0, 5'd0, 5'd10); step("fl_redisp");
        set_wb(5, 32'd10, 32'h60000104);                            step("fl_wb");
        set_commit(5);                                              step("fl_commit");
        chk("fl_inst", PW'(rvfi_inst), PW'(32'h00a00513));
        chk("fl_order", PW'(rvfi_order), PW'(5));

        // Write to x0 is reported as zero
        set_disp(7, 32'h00000013, 32'h60000104, 5'd0, 5'd0, 5'd0); step("x0_disp");
        set_wb(7, 32'h1234, 32'h60000108);                          step("x0_wb");
        set_commit(7);                                              step("x0_commit");
        chk("x0_rd_wdata", PW'(rvfi_rd_wdata), PW'(0));

        // Dispatch and commit on the same tag: old entry out, new entry in
        set_disp(8, 32'h00108093, 32'h60000200, 5'd1, 5'd0, 5'd1); step("rd_disp");
        set_wb(8, 32'h2, 32'h60000204);                             step("rd_wb");
        set_commit(8); set_disp(8, 32'h00208093, 32'h60000204, 5'd1, 5'd0, 5'd1); step("rd_both");
        chk("rd_old_inst", PW'(rvfi_inst), PW'(32'h00108093));
        set_wb(8, 32'h4, 32'h60000208); set_commit(8);              step("rd_new");
        chk("rd_new_inst", PW'(rvfi_inst), PW'(32'h00208093));

        // Randomized in-order stream
        flush = 1; step("rnd_start");
        tail = 0;
        for (int c = 0; c < 600; c++) begin
            int h, k;
            if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
                h = q[0];
                if (m[h].wd) begin
                    set_commit(h); void'(q.pop_front());
                end else if ($urandom_range(0, 2) == 0) begin
                    set_wb(h, $urandom, $urandom); set_commit(h); void'(q.pop_front());
                end
            end
            if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
                k = q[$urandom_range(0, q.size() - 1)];
                set_opnd(k, $urandom, $urandom);
            end
            if (q.size() > 0 && !wb_valid && $urandom_range(0, 2) == 0) begin
                k = q[$urandom_range(0, q.size() - 1)];
                set_wb(k, $urandom, $urandom);
            end
            if (q.size() > 0 && $urandom_range(0, 3) == 0) begin
                k = q[$urandom_range(0, q.size() - 1)];
                set_mem(k, $urandom, 4'($urandom), 4'($urandom), $urandom, $urandom);
            end
            if (q.size() < 15 && $urandom_range(0, 2) != 0) begin
                set_disp(tail % 16, $urandom, $urandom,
                         ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                         ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                         ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
                q.push_back(tail % 16);
                tail++;
            end
            if ($urandom_range(0, 39) == 0) begin
                flush = 1;
                q.delete();
            end
            step("rnd");
        end

        // Reset in the middle of a packet
        flush = 1; step("mr_flush");
        set_disp(2, 32'h00700093, 32'h60000300, 5'd0, 5'd0, 5'd1); step("mr_disp");
        set_wb(2, 32'd7, 32'h60000304);                             step("mr_wb");
        set_commit(2);                                              step("mr_commit");
        rst = 1'b1;
        #1;
        chk("mr_valid", PW'(rvfi_valid), '0);
        chk("mr_order", PW'(rvfi_order), '0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        set_disp(3, 32'h00900093, 32'h60000400, 5'd0, 5'd0, 5'd1); step("ar_disp");
        set_wb(3, 32'd9, 32'h60000404);                             step("ar_wb");
        set_commit(3);                                              step("ar_commit");
        chk("ar_order", PW'(rvfi_order), PW'(0));

        // Commit of an unallocated tag
        flush = 1; step("ua_flush");
        set_commit(7); step("ua_commit");
`ifdef RVFI_CHECK_EN
        chk("ua_err_set", PW'(err), PW'(1));
`endif
        repeat (3) step("ua_idle");
`ifdef RVFI_CHECK_EN
        chk("ua_err_sticky", PW'(err), PW'(1));
`endif
        rst = 1'b1;
        #1;
        chk("ua_err_rst", PW'(err), '0);
        @(negedge clk);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
